// File: rtl/divisor_dispatcher.sv
// Operand FIFO and START/DONE scheduler placed in front of divisor_top.
// Zero denominators are answered locally; a watchdog bounds each wait.
module divisor_dispatcher #(
  parameter int SIZE    = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SIZE-1:0]  IN_NUM,
  input  logic [SIZE-1:0]  IN_DEN,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             DIV_START,
  output logic [SIZE-1:0]  DIV_NUM,
  output logic [SIZE-1:0]  DIV_DEN,
  input  logic             DIV_DONE,
  input  logic [SIZE-1:0]  DIV_COC,
  input  logic [SIZE-1:0]  DIV_RES,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [SIZE-1:0]  OUT_COC,
  output logic [SIZE-1:0]  OUT_RES,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_DZ,
  output logic             OUT_ERR,
  output logic             BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0]  num_mem [DEPTH];
  logic [SIZE-1:0]  den_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    wd_cnt;
  logic [TAG_W-1:0] tag_q;

  logic             push, pop;
  logic             ld_div, ld_out;
  logic             wd_clr, wd_inc;
  logic [SIZE-1:0]  h_num, h_den;
  logic [TAG_W-1:0] h_tag;
  logic [SIZE-1:0]  coc_d, res_d;
  logic [TAG_W-1:0] tag_d;
  logic             dz_d, err_d;

  assign IN_READY  = count < CW'(DEPTH);
  assign push      = IN_VALID && IN_READY;
  assign h_num     = num_mem[rd_ptr];
  assign h_den     = den_mem[rd_ptr];
  assign h_tag     = tag_mem[rd_ptr];
  assign DIV_START = state_q == ISSUE;
  assign BUSY      = (state_q != IDLE) || (count != '0) || OUT_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        num_mem[i] <= '0;
        den_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
    end else if (push) begin
      num_mem[wr_ptr] <= IN_NUM;
      den_mem[wr_ptr] <= IN_DEN;
      tag_mem[wr_ptr] <= IN_TAG;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pop only with an empty slot: one op in flight or held at most.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ld_div  = 1'b0;
    ld_out  = 1'b0;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    coc_d   = '0;
    res_d   = '0;
    tag_d   = tag_q;
    dz_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((count != '0) && !OUT_VALID) begin
          pop = 1'b1;
          if (h_den == '0) begin
            ld_out = 1'b1;
            coc_d  = '1;
            res_d  = h_num;
            tag_d  = h_tag;
            dz_d   = 1'b1;
          end else begin
            ld_div  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (DIV_DONE) begin
          ld_out  = 1'b1;
          coc_d   = DIV_COC;
          res_d   = DIV_RES;
          state_d = IDLE;
        end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
          ld_out  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      wd_cnt  <= '0;
      DIV_NUM <= '0;
      DIV_DEN <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (wd_clr)      wd_cnt <= '0;
      else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
      if (ld_div) begin
        DIV_NUM <= h_num;
        DIV_DEN <= h_den;
        tag_q   <= h_tag;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_COC   <= '0;
      OUT_RES   <= '0;
      OUT_TAG   <= '0;
      OUT_DZ    <= 1'b0;
      OUT_ERR   <= 1'b0;
    end else if (ld_out) begin
      OUT_VALID <= 1'b1;
      OUT_COC   <= coc_d;
      OUT_RES   <= res_d;
      OUT_TAG   <= tag_d;
      OUT_DZ    <= dz_d;
      OUT_ERR   <= err_d;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
